// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: sample input, result output and status signals of the frame accumulator
interface sum_accumulator_if #(
  parameter int IN_W = 25,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
);
  logic [IN_W-1:0] IN_DATA;
  logic IN_VALID;
  logic IN_READY;
  logic [LEN_W-1:0] FRAME_LEN;
  logic [ACC_W-1:0] OUT_DATA;
  logic OUT_VALID;
  logic OUT_READY;
  logic OUT_OVF;
  logic BUSY;
  modport slave (
    input IN_DATA, IN_VALID, FRAME_LEN, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID, OUT_OVF, BUSY
  );
  modport master (
    output IN_DATA, IN_VALID, FRAME_LEN, OUT_READY,
    input IN_READY, OUT_DATA, OUT_VALID, OUT_OVF, BUSY
  );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: saturating per-frame sum of signed adder-tree samples with a valid/ready result
module sum_accumulator #(
  parameter int IN_W = 25,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input logic CLK,
  input logic RST_N,
  sum_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};
  state_t state, state_nx;
  logic [ACC_W-1:0] acc, add_res;
  logic [ACC_W:0] in_ext, sum;
  logic [LEN_W:0] cnt, cnt_inc, len, flen;
  logic ovf, ovf_now, take;
  assign in_ext = {{(ACC_W+1-IN_W){bus.IN_DATA[IN_W-1]}}, bus.IN_DATA};
  assign sum = {acc[ACC_W-1], acc} + in_ext;
  assign ovf_now = sum[ACC_W] ^ sum[ACC_W-1];
  assign add_res = ovf_now ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
  assign cnt_inc = cnt + ONE;
  // a zero length field means a full 2^LEN_W frame, hence the extra MSB
  assign flen = {bus.FRAME_LEN == '0, bus.FRAME_LEN};
  assign take = bus.IN_VALID && state != HOLD;
  always_comb begin
    state_nx = state;
    if (state == IDLE && take) state_nx = flen == ONE ? HOLD : ACCUM;
    if (state == ACCUM && take && cnt_inc == len) state_nx = HOLD;
    if (state == HOLD && bus.OUT_READY) state_nx = IDLE;
    bus.IN_READY = state != HOLD;
    bus.OUT_VALID = state == HOLD;
    bus.BUSY = state != IDLE;
    bus.OUT_DATA = state == HOLD ? acc : '0;
    bus.OUT_OVF = state == HOLD && ovf;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      len <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        acc <= state == IDLE ? in_ext[ACC_W-1:0] : add_res;
        ovf <= state != IDLE && (ovf || ovf_now);
        cnt <= state == IDLE ? ONE : cnt_inc;
        if (state == IDLE) len <= flen;
      end
    end
  end
endmodule
